apb_mem_slave: RTL and testbench
================================

# apb_mem_slave

APB slave front end that converts APB transfers into single-cycle strobes for the team's 8-bit × 256 synchronous memory. It sits directly upstream of that memory: it drives its `ce`/`rden`/`wren`/`addr`/`wr_data` and captures its 1-cycle-latency `rd_data`. It adds configurable wait states, address-range and read-only-region error reporting, and a registered read-data path.

## Interface
- `ADDR_W`, 8: APB and memory address width.
- `DATA_W`, 8: data width.
- `MEM_DEPTH`, 256: valid locations are 0..MEM_DEPTH-1.
- `RO_LIMIT`, 0: writes to addresses < RO_LIMIT are rejected. 0 means no read-only region.
- `WAIT_STATES`, 0: extra access cycles, range 0..15.

Ports:
- `clk` in 1: single clock; all flops on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `psel`, `penable`, `pwrite` in 1: APB control.
- `paddr` in ADDR_W: APB address.
- `pwdata` in DATA_W: APB write data.
- `prdata` out DATA_W: registered read data.
- `pready` out 1: transfer-complete indicator.
- `pslverr` out 1: error response, valid while `pready`=1.
- `mem_ce`, `mem_rden`, `mem_wren` out 1: registered memory strobes. `mem_rden` and `mem_wren` are never high together.
- `mem_addr` out ADDR_W: registered memory address.
- `mem_wr_data` out DATA_W: registered memory write data.
- `mem_rd_data` in DATA_W: memory read data, valid the cycle after the read edge.

## Operation
- FSM states: IDLE, MEM, WAIT, RESP.
- **IDLE**
  - On an edge with `psel`=1 and `penable`=0 (setup), latch `paddr`, `pwdata` and `pwrite`, then decode.
  - Error if `paddr` ≥ MEM_DEPTH, or if `pwrite`=1 and `paddr` < RO_LIMIT.
  - Error: go to RESP with `pslverr` set. No memory strobe is issued.
  - OK: set `mem_ce`=1, plus `mem_rden`=!pwrite or `mem_wren`=pwrite, and load `mem_addr`/`mem_wr_data`. Go to MEM.
- **MEM**
  - The memory performs the access at this edge. Clear all strobes.
  - Load the wait counter with WAIT_STATES and go to WAIT.
- **WAIT**
  - While the counter ≠ 0, decrement it.
  - When the counter = 0, load `prdata` ← `mem_rd_data` (reads only; writes leave `prdata` unchanged) and go to RESP.
- **RESP**
  - `pready`=1, and `pslverr` reflects the decode result.
  - On an edge with `psel`=1, `penable`=1 and `pready`=1: clear `pready` and `pslverr`, go to IDLE.
- Abort: `psel`=0 in any non-IDLE state returns the FSM to IDLE at the next edge.
  - Strobes are cleared.
  - A memory write already issued is not undone.
  - `pready` is never asserted for the aborted transfer.
- `penable`=1 seen in IDLE without a prior setup is ignored.
- Address arithmetic is unsigned, and the decode compare is ADDR_W+1 bits wide, so MEM_DEPTH=256 never flags an error.

## Timing
- Reset values: state IDLE; `prdata`=0; `pready`=0; `pslverr`=0; `mem_ce`, `mem_rden`, `mem_wren` all 0; `mem_addr`=0; `mem_wr_data`=0; wait counter 0.
- Reset asserted mid-transfer forces all of the above immediately (asynchronous reset).
- Edges are numbered E0 (setup sampled), E1, E2, …
- OK transfer:
  - Strobes are high for exactly one cycle, between E0 and E1.
  - `pready` rises after edge E2+WAIT_STATES.
  - Total wait cycles with `pready`=0: 2+WAIT_STATES.
- Error transfer: `pready`=`pslverr`=1 in the first access cycle (zero wait). There is no memory activity.
- Back-to-back: a new setup is accepted in the cycle immediately after completion (IDLE).
- `pready`, `pslverr`, `prdata` and all memory outputs are flop outputs. No combinational path runs from APB inputs to outputs.

## Structure
- Package `apb_mem_pkg` holds:
  - the `state_t` enum (IDLE, MEM, WAIT, RESP);
  - `WAIT_CNT_W`=4;
  - default constants for ADDR_W, DATA_W and MEM_DEPTH.
- Single module with no sub-module. The wait counter is small enough to be inline.
- A top-level `apb_mem_top` instantiates `apb_mem_slave` and the memory, connecting `mem_*` to the memory's ports one-to-one.

## Test plan
- Write 0xA5 to addr 0x10, then read 0x10 (WAIT_STATES=0).
  - Each transfer: `pready` high on the 3rd access cycle.
  - `prdata`=0xA5, `pslverr`=0.
  - Exactly one `mem_ce` pulse per transfer.
- WAIT_STATES=3, read addr 0xFF after writing 0x3C: `pready` high on the 6th access cycle, `prdata`=0x3C.
- MEM_DEPTH=128, read addr 0x80: `pready`=`pslverr`=1 on the 1st access cycle, `mem_ce` stays 0, `prdata` unchanged.
- RO_LIMIT=0x20, write 0x77 to 0x05: `pslverr`=1 and no `mem_wren`. A subsequent read of 0x05 returns the prior content with `pslverr`=0.
- Reset and abort:
  - Assert `rst_n`=0 while in WAIT: all outputs are 0 immediately, and the next transfer completes normally.
  - Drop `psel` in MEM: FSM returns to IDLE and `pready` never rises.

Source files
------------

// File: rtl/apb_mem_pkg.sv
// Shared types and default sizing for the APB front end of the 8-bit x 256 synchronous memory.
package apb_mem_pkg;

   localparam int DEF_ADDR_W    = 8;
   localparam int DEF_DATA_W    = 8;
   localparam int DEF_MEM_DEPTH = 256;
   localparam int WAIT_CNT_W    = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MEM  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } state_t;

endpackage

// File: rtl/apb_mem_ram.sv
// Synchronous single-port memory: write and read happen on the strobed edge, read data
// appears the following cycle and holds until the next read.
module apb_mem_ram
   import apb_mem_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              ce,
   input  logic              rden,
   input  logic              wren,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (ce && wren) begin
         mem_q[addr] <= wr_data;
      end
      if (ce && rden) begin
         rd_data <= mem_q[addr];
      end
   end

endmodule

// File: rtl/apb_mem_top.sv
// APB-addressable memory: the slave front end wired one-to-one onto the synchronous RAM.
module apb_mem_top
   import apb_mem_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int MEM_DEPTH   = DEF_MEM_DEPTH,
   parameter int RO_LIMIT    = 0,
   parameter int WAIT_STATES = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [ADDR_W-1:0] paddr,
   input  logic [DATA_W-1:0] pwdata,
   output logic [DATA_W-1:0] prdata,
   output logic              pready,
   output logic              pslverr
);

   logic              mem_ce;
   logic              mem_rden;
   logic              mem_wren;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wr_data;
   logic [DATA_W-1:0] mem_rd_data;

   apb_mem_slave #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .MEM_DEPTH   (MEM_DEPTH),
      .RO_LIMIT    (RO_LIMIT),
      .WAIT_STATES (WAIT_STATES)
   ) u_slave (
      .clk         (clk),
      .rst_n       (rst_n),
      .psel        (psel),
      .penable     (penable),
      .pwrite      (pwrite),
      .paddr       (paddr),
      .pwdata      (pwdata),
      .prdata      (prdata),
      .pready      (pready),
      .pslverr     (pslverr),
      .mem_ce      (mem_ce),
      .mem_rden    (mem_rden),
      .mem_wren    (mem_wren),
      .mem_addr    (mem_addr),
      .mem_wr_data (mem_wr_data),
      .mem_rd_data (mem_rd_data)
   );

   apb_mem_ram #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W)
   ) u_ram (
      .clk     (clk),
      .ce      (mem_ce),
      .rden    (mem_rden),
      .wren    (mem_wren),
      .addr    (mem_addr),
      .wr_data (mem_wr_data),
      .rd_data (mem_rd_data)
   );

endmodule

// File: rtl/apb_mem_slave.sv
// APB slave that turns each transfer into one registered memory strobe, with programmable
// wait states, out-of-range / read-only error decode and a registered read-data return.
module apb_mem_slave
   import apb_mem_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int MEM_DEPTH   = DEF_MEM_DEPTH,
   parameter int RO_LIMIT    = 0,
   parameter int WAIT_STATES = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [ADDR_W-1:0] paddr,
   input  logic [DATA_W-1:0] pwdata,
   output logic [DATA_W-1:0] prdata,
   output logic              pready,
   output logic              pslverr,
   output logic              mem_ce,
   output logic              mem_rden,
   output logic              mem_wren,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wr_data,
   input  logic [DATA_W-1:0] mem_rd_data
);

   // One extra bit lets MEM_DEPTH = 2**ADDR_W be expressed without ever flagging.
   localparam logic [ADDR_W:0]           DEPTH_LIM = (ADDR_W+1)'(MEM_DEPTH);
   localparam logic [WAIT_CNT_W-1:0]     WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);
   localparam logic [WAIT_CNT_W-1:0]     CNT_ONE   = WAIT_CNT_W'(1);

   state_t                  state_q, state_d;
   logic [WAIT_CNT_W-1:0]   wcnt_q, wcnt_d;
   logic                    wr_q, wr_d;
   logic [DATA_W-1:0]       prdata_q, prdata_d;
   logic                    pready_q, pready_d;
   logic                    pslverr_q, pslverr_d;
   logic                    ce_q, ce_d;
   logic                    rden_q, rden_d;
   logic                    wren_q, wren_d;
   logic [ADDR_W-1:0]       addr_q, addr_d;
   logic [DATA_W-1:0]       wdata_q, wdata_d;

   logic                    range_err;
   logic                    ro_hit;
   logic                    dec_err;

   assign range_err = ({1'b0, paddr} >= DEPTH_LIM);

   generate
      if (RO_LIMIT == 0) begin : g_no_ro
         assign ro_hit = 1'b0;
      end else begin : g_ro
         localparam logic [ADDR_W:0] RO_LIM = (ADDR_W+1)'(RO_LIMIT);
         assign ro_hit = ({1'b0, paddr} < RO_LIM);
      end
   endgenerate

   assign dec_err = range_err || (pwrite && ro_hit);

   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      wr_d      = wr_q;
      prdata_d  = prdata_q;
      pready_d  = pready_q;
      pslverr_d = pslverr_q;
      ce_d      = 1'b0;
      rden_d    = 1'b0;
      wren_d    = 1'b0;
      addr_d    = addr_q;
      wdata_d   = wdata_q;

      // Master walked away: drop everything; an already-issued write stays in memory.
      if ((state_q != IDLE) && !psel) begin
         state_d   = IDLE;
         pready_d  = 1'b0;
         pslverr_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (psel && !penable) begin
                  wr_d = pwrite;
                  if (dec_err) begin
                     pready_d  = 1'b1;
                     pslverr_d = 1'b1;
                     state_d   = RESP;
                  end else begin
                     ce_d    = 1'b1;
                     rden_d  = !pwrite;
                     wren_d  = pwrite;
                     addr_d  = paddr;
                     wdata_d = pwdata;
                     state_d = MEM;
                  end
               end
            end
            MEM: begin
               wcnt_d  = WAIT_LOAD;
               state_d = WAIT;
            end
            WAIT: begin
               if (wcnt_q != '0) begin
                  wcnt_d = wcnt_q - CNT_ONE;
               end else begin
                  if (!wr_q) begin
                     prdata_d = mem_rd_data;
                  end
                  pready_d = 1'b1;
                  state_d  = RESP;
               end
            end
            RESP: begin
               if (penable && pready_q) begin
                  pready_d  = 1'b0;
                  pslverr_d = 1'b0;
                  state_d   = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         wcnt_q    <= '0;
         wr_q      <= 1'b0;
         prdata_q  <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         ce_q      <= 1'b0;
         rden_q    <= 1'b0;
         wren_q    <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         wcnt_q    <= wcnt_d;
         wr_q      <= wr_d;
         prdata_q  <= prdata_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         ce_q      <= ce_d;
         rden_q    <= rden_d;
         wren_q    <= wren_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
      end
   end

   assign prdata      = prdata_q;
   assign pready      = pready_q;
   assign pslverr     = pslverr_q;
   assign mem_ce      = ce_q;
   assign mem_rden    = rden_q;
   assign mem_wren    = wren_q;
   assign mem_addr    = addr_q;
   assign mem_wr_data = wdata_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Drives three differently-configured slaves (with behavioural memories) and one full
// apb_mem_top through shared APB wires; each transfer is scored against an array model.
module tb_apb_mem_slave;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       psel, penable, pwrite;
   logic [7:0] paddr, pwdata;
   int         sel;

   logic       psel_v [4];
   logic [7:0] prd    [4];
   logic       prdy   [4];
   logic       perr   [4];
   logic       mce    [3];
   logic       mrden  [3];
   logic       mwren  [3];
   logic [7:0] maddr  [3];
   logic [7:0] mwd    [3];
   logic [7:0] mrd    [3];

   logic [7:0] tbm [3][256];
   logic       inited = 1'b0;
   int         ce_cnt [3] = '{0, 0, 0};
   int         we_cnt [3] = '{0, 0, 0};
   int         both_cnt = 0;

   int         tests = 0;
   int         fails = 0;

   int         cfg_depth [4] = '{256, 256, 128, 256};
   int         cfg_ro    [4] = '{0, 0, 32, 0};
   int         cfg_ws    [4] = '{0, 3, 1, 2};
   logic [7:0] ref_mem [4][256];
   logic [7:0] ref_prd [4];

   always_comb begin
      for (int i = 0; i < 4; i++) psel_v[i] = psel && (sel == i);
   end

   apb_mem_slave #(.WAIT_STATES(0)) u_a (
      .clk(clk), .rst_n(rst_n), .psel(psel_v[0]), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prd[0]), .pready(prdy[0]), .pslverr(perr[0]),
      .mem_ce(mce[0]), .mem_rden(mrden[0]), .mem_wren(mwren[0]), .mem_addr(maddr[0]),
      .mem_wr_data(mwd[0]), .mem_rd_data(mrd[0]));

   apb_mem_slave #(.WAIT_STATES(3)) u_b (
      .clk(clk), .rst_n(rst_n), .psel(psel_v[1]), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prd[1]), .pready(prdy[1]), .pslverr(perr[1]),
      .mem_ce(mce[1]), .mem_rden(mrden[1]), .mem_wren(mwren[1]), .mem_addr(maddr[1]),
      .mem_wr_data(mwd[1]), .mem_rd_data(mrd[1]));

   apb_mem_slave #(.MEM_DEPTH(128), .RO_LIMIT(32), .WAIT_STATES(1)) u_c (
      .clk(clk), .rst_n(rst_n), .psel(psel_v[2]), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prd[2]), .pready(prdy[2]), .pslverr(perr[2]),
      .mem_ce(mce[2]), .mem_rden(mrden[2]), .mem_wren(mwren[2]), .mem_addr(maddr[2]),
      .mem_wr_data(mwd[2]), .mem_rd_data(mrd[2]));

   apb_mem_top #(.WAIT_STATES(2)) u_d (
      .clk(clk), .rst_n(rst_n), .psel(psel_v[3]), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prd[3]), .pready(prdy[3]), .pslverr(perr[3]));

   // Behavioural 1-cycle-latency memories with known initial contents, plus strobe counters.
   always @(posedge clk) begin
      if (!rst_n && !inited) begin
         for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 256; j++) tbm[i][j] <= 8'(j) ^ 8'h5A;
            mrd[i] <= 8'h00;
         end
         inited <= 1'b1;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (mce[i] && mwren[i]) tbm[i][maddr[i]] <= mwd[i];
            if (mce[i] && mrden[i]) mrd[i] <= tbm[i][maddr[i]];
         end
      end
      for (int i = 0; i < 3; i++) begin
         if (mce[i])              ce_cnt[i] <= ce_cnt[i] + 1;
         if (mwren[i])            we_cnt[i] <= we_cnt[i] + 1;
         if (mrden[i] && mwren[i]) both_cnt <= both_cnt + 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Reference: error, latency, memory and prdata follow directly from the decode rules.
   task automatic model_xfer(input int d, input bit wr, input logic [7:0] a, input logic [7:0] wd,
                             output logic [7:0] rd, output logic er, output int cyc,
                             output int ce, output int we);
      er  = (int'(a) >= cfg_depth[d]) || (wr && (int'(a) < cfg_ro[d]));
      cyc = er ? 1 : 3 + cfg_ws[d];
      ce  = er ? 0 : 1;
      we  = (!er && wr) ? 1 : 0;
      if (!er && wr)  ref_mem[d][a] = wd;
      if (!er && !wr) ref_prd[d] = ref_mem[d][a];
      rd = ref_prd[d];
   endtask

   // Called at a negedge; returns at a negedge with psel released (a following call is back-to-back).
   task automatic do_xfer(input int d, input bit wr, input logic [7:0] a, input logic [7:0] wd,
                          output logic [7:0] rd, output logic er, output int cyc,
                          output int ced, output int wed);
      int ce0 = 0;
      int we0 = 0;
      if (d < 3) begin
         ce0 = ce_cnt[d];
         we0 = we_cnt[d];
      end
      sel = d; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
      @(negedge clk);
      penable = 1'b1;
      cyc = 1;
      while (prdy[d] !== 1'b1 && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      if (prdy[d] !== 1'b1) begin
         tests++;
         fails++;
         $display("FAIL xfer_timeout dut=%0d actual=pready_low required=pready_high", d);
      end
      rd = prd[d];
      er = perr[d];
      @(negedge clk);
      chk("pready_clear", 32'(prdy[d]), 0);
      psel = 1'b0; penable = 1'b0;
      ced = 0;
      wed = 0;
      if (d < 3) begin
         ced = ce_cnt[d] - ce0;
         wed = we_cnt[d] - we0;
      end
   endtask

   typedef struct {
      int         d;
      bit         wr;
      logic [7:0] a;
      logic [7:0] wd;
      logic [7:0] rd;
      bit         err;
      int         cyc;
   } vec_t;

   vec_t       vt [16];
   logic [7:0] r_rd, e_rd;
   logic       r_err, e_err;
   int         r_cyc, e_cyc, r_ce, e_ce, r_we, e_we;
   int         d;
   bit         wr;
   logic [7:0] a, wd;
   int         ce0, we0;
   bit         seen;

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=still_running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0]  = '{0, 1'b1, 8'h10, 8'hA5, 8'h00, 1'b0, 3};
      vt[1]  = '{0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, 3};
      vt[2]  = '{0, 1'b1, 8'hFF, 8'h5C, 8'hA5, 1'b0, 3};
      vt[3]  = '{0, 1'b0, 8'hFF, 8'h00, 8'h5C, 1'b0, 3};
      vt[4]  = '{1, 1'b1, 8'hFF, 8'h3C, 8'h00, 1'b0, 6};
      vt[5]  = '{1, 1'b0, 8'hFF, 8'h00, 8'h3C, 1'b0, 6};
      vt[6]  = '{2, 1'b0, 8'h80, 8'h00, 8'h00, 1'b1, 1};
      vt[7]  = '{2, 1'b1, 8'h05, 8'h77, 8'h00, 1'b1, 1};
      vt[8]  = '{2, 1'b0, 8'h05, 8'h00, 8'h5F, 1'b0, 4};
      vt[9]  = '{2, 1'b1, 8'h20, 8'hC3, 8'h5F, 1'b0, 4};
      vt[10] = '{2, 1'b0, 8'h20, 8'h00, 8'hC3, 1'b0, 4};
      vt[11] = '{2, 1'b0, 8'h7F, 8'h00, 8'h25, 1'b0, 4};
      vt[12] = '{2, 1'b1, 8'h1F, 8'h12, 8'h25, 1'b1, 1};
      vt[13] = '{2, 1'b0, 8'h1F, 8'h00, 8'h45, 1'b0, 4};
      vt[14] = '{3, 1'b1, 8'h33, 8'h6B, 8'h00, 1'b0, 5};
      vt[15] = '{3, 1'b0, 8'h33, 8'h00, 8'h6B, 1'b0, 5};

      for (int k = 0; k < 4; k++) begin
         for (int j = 0; j < 256; j++) ref_mem[k][j] = 8'(j) ^ 8'h5A;
         ref_prd[k] = 8'h00;
      end

      rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = 8'h00; pwdata = 8'h00; sel = 0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("rst_prdata%0d", k), 32'(prd[k]), 0);
         chk($sformatf("rst_pready_pslverr%0d", k), 32'({prdy[k], perr[k]}), 0);
      end
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rst_mem%0d", k),
             32'({mce[k], mrden[k], mwren[k], maddr[k], mwd[k]}), 0);
      end
      rst_n = 1'b1;
      @(negedge clk);

      for (int k = 0; k < 16; k++) begin
         do_xfer(vt[k].d, vt[k].wr, vt[k].a, vt[k].wd, r_rd, r_err, r_cyc, r_ce, r_we);
         model_xfer(vt[k].d, vt[k].wr, vt[k].a, vt[k].wd, e_rd, e_err, e_cyc, e_ce, e_we);
         chk($sformatf("vec%0d_cyc", k), 32'(r_cyc), 32'(vt[k].cyc));
         chk($sformatf("vec%0d_pslverr", k), 32'(r_err), 32'(vt[k].err));
         chk($sformatf("vec%0d_prdata", k), 32'(r_rd), 32'(vt[k].rd));
         if (vt[k].d < 3) begin
            chk($sformatf("vec%0d_ce_pulses", k), 32'(r_ce), vt[k].err ? 0 : 1);
            chk($sformatf("vec%0d_wren_pulses", k), 32'(r_we), (vt[k].wr && !vt[k].err) ? 1 : 0);
         end
      end

      // Reset asserted while slave B sits in WAIT.
      sel = 1; psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'hFF; pwdata = 8'hEE;
      @(negedge clk);
      penable = 1'b1;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_in_wait_outs",
          32'({prd[1], prdy[1], perr[1], mce[1], mrden[1], mwren[1], maddr[1], mwd[1]}), 0);
      @(negedge clk);
      psel = 1'b0; penable = 1'b0; rst_n = 1'b1;
      for (int k = 0; k < 4; k++) ref_prd[k] = 8'h00;
      @(negedge clk);
      do_xfer(1, 1'b0, 8'hFF, 8'h00, r_rd, r_err, r_cyc, r_ce, r_we);
      model_xfer(1, 1'b0, 8'hFF, 8'h00, e_rd, e_err, e_cyc, e_ce, e_we);
      chk("post_rst_cyc", 32'(r_cyc), 32'(e_cyc));
      chk("post_rst_prdata", 32'(r_rd), 32'(e_rd));

      // Abort in MEM: the write still lands, pready never rises.
      ce0 = ce_cnt[0]; we0 = we_cnt[0];
      sel = 0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h40; pwdata = 8'h99;
      @(negedge clk);
      psel = 1'b0;
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (prdy[0] !== 1'b0) seen = 1'b1;
      end
      chk("abort_pready_seen", 32'(seen), 0);
      chk("abort_ce_pulses", 32'(ce_cnt[0] - ce0), 1);
      chk("abort_wren_pulses", 32'(we_cnt[0] - we0), 1);
      ref_mem[0][8'h40] = 8'h99;
      do_xfer(0, 1'b0, 8'h40, 8'h00, r_rd, r_err, r_cyc, r_ce, r_we);
      model_xfer(0, 1'b0, 8'h40, 8'h00, e_rd, e_err, e_cyc, e_ce, e_we);
      chk("after_abort_cyc", 32'(r_cyc), 32'(e_cyc));
      chk("after_abort_prdata", 32'(r_rd), 32'(e_rd));

      // penable without a setup phase must not start anything.
      ce0 = ce_cnt[0];
      sel = 0; psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 8'h11;
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (prdy[0] !== 1'b0) seen = 1'b1;
      end
      psel = 1'b0; penable = 1'b0;
      chk("no_setup_pready_seen", 32'(seen), 0);
      chk("no_setup_ce_pulses", 32'(ce_cnt[0] - ce0), 0);
      @(negedge clk);

      for (int n = 0; n < 200; n++) begin
         d  = int'($urandom_range(0, 2));
         wr = 1'($urandom_range(0, 1));
         a  = 8'($urandom);
         wd = 8'($urandom);
         do_xfer(d, wr, a, wd, r_rd, r_err, r_cyc, r_ce, r_we);
         model_xfer(d, wr, a, wd, e_rd, e_err, e_cyc, e_ce, e_we);
         chk($sformatf("rnd%0d_cyc", n), 32'(r_cyc), 32'(e_cyc));
         chk($sformatf("rnd%0d_pslverr", n), 32'(r_err), 32'(e_err));
         chk($sformatf("rnd%0d_prdata", n), 32'(r_rd), 32'(e_rd));
         chk($sformatf("rnd%0d_ce_pulses", n), 32'(r_ce), 32'(e_ce));
         chk($sformatf("rnd%0d_wren_pulses", n), 32'(r_we), 32'(e_we));
      end

      chk("rden_wren_overlap", 32'(both_cnt), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
